// File: rtl/word_fifo_if.sv
// Producer/consumer bundle for word_fifo: write strobe/data in, FWFT read data and status out.
// Pure wiring; no state, no latency.
interface word_fifo_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 3
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, rd_data, empty, count, ovf, udf
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, rd_data, empty, count, ovf, udf
    );
endinterface

// File: rtl/word_fifo.sv
// Small FWFT word FIFO: a write at edge N is visible on rd_data after edge N (1 cycle).
// Writes when full are dropped (sticky ovf) unless a pop frees the slot; pops when empty are ignored (sticky udf).
module word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    word_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic full;
    logic empty;
    logic wr_ok;
    logic rd_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A pop on the same edge frees a slot, so a write at full is still accepted.
    assign wr_ok = bus.wr_en & (~full | bus.rd_en);
    assign rd_ok = bus.rd_en & ~empty;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q | (bus.wr_en & ~wr_ok);
        udf_d   = udf_q | (bus.rd_en & empty);

        if (wr_ok) begin
            wp_d = wp_q + AW'(1);
        end
        if (rd_ok) begin
            rp_d = rp_q + AW'(1);
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is not reset; it is masked by empty until written.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wp_q] <= bus.wr_data;
        end
    end

    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.count   = count_q;
    assign bus.ovf     = ovf_q;
    assign bus.udf     = udf_q;
    assign bus.rd_data = empty ? '0 : mem_q[rp_q];
endmodule

// File: tb/tb_word_fifo.sv
// Scoreboard bench for word_fifo: expected words queued on accepted writes, compared on pops.
module tb_word_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;

    word_fifo_if #(.WIDTH(16), .CW(3)) bus ();

    word_fifo #(.WIDTH(16), .DEPTH(4), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        check("count", 32'(bus.count), 32'(m_cnt));
        check("full",  32'(bus.full),  32'(m_cnt == 4));
        check("empty", 32'(bus.empty), 32'(m_cnt == 0));
        check("ovf",   32'(bus.ovf),   32'(m_ovf));
        check("udf",   32'(bus.udf),   32'(m_udf));
        if (m_cnt == 0) check("rd_data_empty", 32'(bus.rd_data), 32'h0);
        else            check("rd_data_head",  32'(bus.rd_data), 32'(exp_q[0]));
    endtask

    // Drives one cycle of stimulus, updates the model, then checks after the edge.
    task automatic cycle(input bit we, input logic [15:0] wd, input bit re);
        bit          w_ok;
        bit          r_ok;
        logic [15:0] e;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        w_ok = we && (m_cnt < 4 || re);
        r_ok = re && (m_cnt > 0);
        if (r_ok) begin
            e = exp_q.pop_front();
            check("pop_data", 32'(bus.rd_data), 32'(e));
        end
        if (we && !w_ok) m_ovf = 1'b1;
        if (re && m_cnt == 0) m_udf = 1'b1;
        if (w_ok) exp_q.push_back(wd);
        m_cnt = exp_q.size();
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check_state();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #2;
        check("rst_empty",   32'(bus.empty),   32'h1);
        check("rst_count",   32'(bus.count),   32'h0);
        check("rst_rd_data", 32'(bus.rd_data), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain_all();
        while (m_cnt > 0) cycle(1'b0, 16'h0, 1'b1);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;

        // Reset then idle
        do_reset();
        check("idle_full", 32'(bus.full), 32'h0);
        check("idle_ovf",  32'(bus.ovf),  32'h0);
        check("idle_udf",  32'(bus.udf),  32'h0);
        cycle(1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0);

        // Fill and drain
        cycle(1'b1, 16'h1111, 1'b0);
        cycle(1'b1, 16'h2222, 1'b0);
        cycle(1'b1, 16'h3333, 1'b0);
        cycle(1'b1, 16'h4444, 1'b0);
        check("fill_full",  32'(bus.full),  32'h1);
        check("fill_count", 32'(bus.count), 32'h4);
        drain_all();
        check("drain_empty", 32'(bus.empty), 32'h1);

        // Overflow drops the extra word
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'hA000 + 16'(i), 1'b0);
        cycle(1'b1, 16'hBEEF, 1'b0);
        check("ovf_set",   32'(bus.ovf),   32'h1);
        check("ovf_count", 32'(bus.count), 32'h4);
        drain_all();

        // Simultaneous write+pop while full
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0100 + 16'(i), 1'b0);
        cycle(1'b1, 16'h5555, 1'b1);
        check("fullrw_count", 32'(bus.count), 32'h4);
        check("fullrw_ovf",   32'(bus.ovf),   32'h0);
        drain_all();

        // Simultaneous write+pop while empty
        cycle(1'b1, 16'h7777, 1'b1);
        check("emptyrw_count", 32'(bus.count),   32'h1);
        check("emptyrw_udf",   32'(bus.udf),     32'h1);
        check("emptyrw_data",  32'(bus.rd_data), 32'h7777);
        drain_all();
        cycle(1'b0, 16'h0, 1'b1);

        // Wrap-around streaming
        do_reset();
        cycle(1'b1, 16'h0001, 1'b0);
        cycle(1'b1, 16'h0002, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 16'h0003 + 16'(i), 1'b1);
            check("stream_count", 32'(bus.count), 32'h2);
        end
        check("stream_ovf", 32'(bus.ovf), 32'h0);
        check("stream_udf", 32'(bus.udf), 32'h0);
        drain_all();

        // Reset mid-operation
        cycle(1'b1, 16'h0A0A, 1'b0);
        cycle(1'b1, 16'h0B0B, 1'b0);
        cycle(1'b1, 16'h0D0D, 1'b0);
        check("pre_rst_count", 32'(bus.count), 32'h3);
        do_reset();
        cycle(1'b1, 16'h0C0C, 1'b0);
        check("post_rst_head", 32'(bus.rd_data), 32'h0C0C);
        drain_all();

        // Random traffic against the scoreboard
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        drain_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
